// File: rtl/tlcd_pkg.sv
// Shared encodings for the text-LCD read engine.
// Optional poll timeout is enabled with TLCD_POLL_TIMEOUT_EN.
package tlcd_pkg;

  typedef logic [1:0] op_t;
  typedef logic [2:0] state_t;

  localparam op_t OP_STATUS = 2'b00;
  localparam op_t OP_DATA   = 2'b01;
  localparam op_t OP_POLL   = 2'b10;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_SETUP = 3'd1;
  localparam state_t S_EHIGH = 3'd2;
  localparam state_t S_HOLD  = 3'd3;
  localparam state_t S_DONE  = 3'd4;

  localparam int BF_BIT = 7;

  function automatic int max3(int a, int b, int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/tlcd_reader_timer.sv
// Loadable phase down-counter; tc is high once the count reaches zero.
module tlcd_phase_timer #(
  parameter int W = 5
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/tlcd_reader.sv
// HD44780 read-side engine: status read, data read, busy poll.
// Define TLCD_POLL_TIMEOUT_EN to bound polls to POLL_TIMEOUT pulses.
module tlcd_reader
  import tlcd_pkg::*;
#(
  parameter int T_AS         = 2,
  parameter int T_EH         = 12,
  parameter int T_EL         = 25,
  parameter int POLL_TIMEOUT = 1000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       REQ,
  input  logic [1:0] OP,
  output logic       READY,
  output logic       VALID,
  output logic [7:0] RD_DATA,
  output logic       BF,
  output logic [6:0] AC,
  output logic       TIMEOUT,
  output logic       TLCD_BUS_REQ,
  output logic       TLCD_DATA_RELEASE,
  output logic       TLCD_E,
  output logic       TLCD_RS,
  output logic       TLCD_RW,
  input  logic [7:0] TLCD_DATA_IN
);

  localparam int TW = $clog2(max3(T_AS, T_EH, T_EL) + 1);

  state_t      state, state_n;
  op_t         op_q;
  logic [7:0]  cap;
  logic        load;
  logic [TW-1:0] load_val;
  logic        tc;
  logic        busy;
  logic        expired;
  logic        accept;
  logic        repoll;

  tlcd_phase_timer #(.W(TW)) u_timer (
    .CLK      (CLK),
    .RST      (RST),
    .load     (load),
    .load_val (load_val),
    .tc       (tc)
  );

  assign accept = (state == S_IDLE) && REQ;
  assign busy   = (op_q == OP_POLL) && cap[BF_BIT];
  assign repoll = (state == S_HOLD) && tc && busy;

`ifdef TLCD_POLL_TIMEOUT_EN
  localparam int PCW = $clog2(POLL_TIMEOUT + 1);

  logic [PCW-1:0] poll_cnt;
  logic           timeout_q;

  assign expired = (poll_cnt == PCW'(POLL_TIMEOUT - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      poll_cnt  <= '0;
      timeout_q <= 1'b0;
    end else if (accept) begin
      poll_cnt  <= '0;
      timeout_q <= 1'b0;
    end else if (repoll) begin
      if (expired)
        timeout_q <= 1'b1;
      else
        poll_cnt <= poll_cnt + 1'b1;
    end
  end

  assign TIMEOUT = timeout_q;
`else
  logic unused_cfg;

  assign unused_cfg = (POLL_TIMEOUT > 0);
  assign expired    = 1'b0;
  assign TIMEOUT    = 1'b0;
`endif

  always_comb begin
    state_n  = state;
    load     = 1'b0;
    load_val = '0;
    unique case (state)
      S_IDLE: if (REQ) begin
        state_n  = S_SETUP;
        load     = 1'b1;
        load_val = TW'(T_AS - 1);
      end
      S_SETUP: if (tc) begin
        state_n  = S_EHIGH;
        load     = 1'b1;
        load_val = TW'(T_EH - 1);
      end
      S_EHIGH: if (tc) begin
        state_n  = S_HOLD;
        load     = 1'b1;
        load_val = TW'(T_EL - 1);
      end
      S_HOLD: if (tc) begin
        if (busy && !expired) begin
          state_n  = S_SETUP;
          load     = 1'b1;
          load_val = TW'(T_AS - 1);
        end else begin
          state_n = S_DONE;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= S_IDLE;
      op_q    <= OP_STATUS;
      cap     <= '0;
      RD_DATA <= '0;
      BF      <= 1'b0;
      AC      <= '0;
    end else begin
      state <= state_n;
      if (accept)
        op_q <= (OP == 2'b11) ? OP_STATUS : OP;
      if (state == S_EHIGH && tc)
        cap <= TLCD_DATA_IN;
      // results land on DONE entry; data reads leave BF/AC alone
      if (state == S_HOLD && state_n == S_DONE) begin
        RD_DATA <= cap;
        if (op_q != OP_DATA) begin
          BF <= cap[BF_BIT];
          AC <= cap[6:0];
        end
      end
    end
  end

  assign READY             = (state == S_IDLE);
  assign VALID             = (state == S_DONE);
  assign TLCD_BUS_REQ      = (state == S_SETUP) || (state == S_EHIGH) ||
                             (state == S_HOLD);
  assign TLCD_DATA_RELEASE = TLCD_BUS_REQ;
  assign TLCD_RW           = TLCD_BUS_REQ;
  assign TLCD_E            = (state == S_EHIGH);
  assign TLCD_RS           = TLCD_BUS_REQ && (op_q == OP_DATA);

endmodule
